trng_seed_fetch: RTL and testbench
==================================

Name: trng_seed_fetch

Overview:
Consumer-side reader for the TRNG byte FIFO. On request, it pops random bytes from the FIFO and packs them into WORD_W-bit words. It delivers a requested number of words to the chaos-map seed/key loader over a valid/ready handshake. It also runs a repetition-count health test on every byte it pops and aborts delivery when the test fails.

Parameters:
WORD_W, 32, output word width; must be a multiple of 8 and at least 16.
REP_LIMIT, 4, number of identical consecutive bytes that trips the health error; range 2..255.

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous, active-low reset
fifo_empty  input  1  TRNG FIFO empty flag
fifo_rd_en  output  1  FIFO pop strobe
fifo_rd_data  input  8  FIFO read data; valid the cycle after fifo_rd_en
start  input  1  single-cycle fetch request
num_words  input  4  words to deliver; sampled on accepted start; 0 means 16
word_data  output  WORD_W  packed random word
word_valid  output  1  word_data is valid
word_ready  input  1  downstream accepts the word
busy  output  1  a fetch is in progress
done  output  1  one-cycle pulse after the last word handshakes
health_err  output  1  sticky repetition-test failure
clear_err  input  1  clears health_err and the repetition history

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs are 0. Byte count, words-left count, previous-byte register and repetition counter are all 0.
- BYTES = WORD_W/8.
- State IDLE:
  - busy=0.
  - start && !health_err: latch the word count (num_words, with 0 mapped to 16), clear the byte count, go to FETCH.
  - start while health_err=1 is ignored.
  - start while busy is ignored.
- State FETCH:
  - fifo_rd_en is combinational: (state==FETCH) && !fifo_empty.
  - When fifo_rd_en=1, go to CAPTURE. Otherwise stay in FETCH with no timeout.
  - At most one read is outstanding at a time.
- State CAPTURE (the cycle after the pop):
  - Shift in: word_data <= {word_data[WORD_W-9:0], fifo_rd_data}. The first byte popped ends up in the MSBs.
  - Health test: if fifo_rd_data equals the previous byte and the history is valid, increment the repetition counter; otherwise load it with 1. Update the previous byte. The history becomes valid after the first capture.
  - If the repetition counter reaches REP_LIMIT on this capture: set health_err, go to IDLE, and do not raise word_valid or done. The partial word is discarded.
  - Otherwise: if byte count == BYTES-1, go to PRESENT; else increment the byte count and go to FETCH.
- State PRESENT:
  - word_valid=1. word_data is held stable. fifo_rd_en=0.
  - On word_valid && word_ready, decrement words-left and clear the byte count.
  - If words-left becomes 0: go to DONE. Otherwise go to FETCH.
  - word_valid drops in the cycle after the handshake.
- State DONE: done=1 for one cycle, then IDLE.
- busy=1 in FETCH, CAPTURE, PRESENT and DONE.
- Throughput: 2 cycles per byte with a non-empty FIFO. An uncongested WORD_W=32 word presents 8 cycles after it starts fetching.
- clear_err (any state):
  - Clears health_err, the repetition counter and history valid.
  - Does not restart an aborted fetch.
  - If asserted in the same cycle as a failing capture, the failure wins (health_err=1).
- The repetition history persists across requests. Only reset and clear_err clear it.
- fifo_empty asserting mid-word stalls in FETCH. Partial word contents are preserved.
- Reset mid-fetch returns to the reset state immediately. No done pulse is generated.

Test Plan:
1. WORD_W=32; start with num_words=1; FIFO holds 0x11,0x22,0x33,0x44 -> exactly 4 single-cycle fifo_rd_en pulses; word_valid with word_data=0x11223344; done pulses one cycle after the handshake; busy low afterwards.
2. num_words=2 with word_ready held low for 10 cycles on the first word -> word_data stable and fifo_rd_en=0 throughout; after the handshake, the second word is fetched; done fires only after the second handshake.
3. num_words=0 with the FIFO prefilled with 64 distinct bytes -> 16 words delivered, 64 pops total, single done pulse.
4. fifo_empty raised after 2 bytes for 20 cycles -> no fifo_rd_en while empty; on resume, the word completes with the first two bytes in the MSBs.
5. REP_LIMIT=4; bytes 0xAA,0xAA,0xAA,0xAA -> health_err=1 the cycle after the 4th capture; busy=0; no word_valid, no done; a subsequent start is ignored; clear_err then start fetches normally.
6. Assert reset_n low during CAPTURE of a fetch with num_words=3 -> all outputs 0 immediately; after release, the block is in IDLE and accepts a new start.

Source files
------------

// File: rtl/trng_seed_fetch.sv
// Consumer-side TRNG FIFO reader: pops bytes, packs them MSB-first into words,
// delivers them over valid/ready and runs a repetition-count health test on every byte.
module trng_seed_fetch #(
  parameter int WORD_W    = 32,
  parameter int REP_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [7:0]        fifo_rd_data,
  input  logic              start,
  input  logic [3:0]        num_words,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              done,
  output logic              health_err,
  input  logic              clear_err,
  output logic [2:0]        state_dbg
);

  // Handshake: a word transfers on any rising edge where word_valid && word_ready;
  // word_data is held stable while word_valid is high and not yet accepted.

  localparam int BYTES = WORD_W / 8;
  localparam int BCW   = $clog2(BYTES);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t         state;
  logic [BCW-1:0] byte_cnt;
  logic [4:0]     words_left;
  logic [7:0]     prev_byte;
  logic [7:0]     rep_cnt;
  logic           hist_valid;
  logic [7:0]     rep_next;
  logic           rep_trip;

  assign state_dbg  = state;
  assign fifo_rd_en = (state == S_FETCH) && !fifo_empty;

  always_comb begin
    rep_next = 8'd1;
    if (hist_valid && (fifo_rd_data == prev_byte)) rep_next = rep_cnt + 8'd1;
    rep_trip = (rep_next == 8'(REP_LIMIT));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      byte_cnt   <= '0;
      words_left <= '0;
      prev_byte  <= '0;
      rep_cnt    <= '0;
      hist_valid <= 1'b0;
      word_data  <= '0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      health_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !health_err) begin
            words_left <= (num_words == 4'd0) ? 5'd16 : {1'b0, num_words};
            byte_cnt   <= '0;
            busy       <= 1'b1;
            state      <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (fifo_rd_en) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          word_data  <= {word_data[WORD_W-9:0], fifo_rd_data};
          prev_byte  <= fifo_rd_data;
          rep_cnt    <= rep_next;
          hist_valid <= 1'b1;
          if (rep_trip) begin
            // Abort: the partial word is never presented.
            health_err <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end else if (byte_cnt == LAST_BYTE) begin
            word_valid <= 1'b1;
            state      <= S_PRESENT;
          end else begin
            byte_cnt <= byte_cnt + BCW'(1);
            state    <= S_FETCH;
          end
        end
        S_PRESENT: begin
          if (word_ready) begin
            word_valid <= 1'b0;
            byte_cnt   <= '0;
            words_left <= words_left - 5'd1;
            if (words_left == 5'd1) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // A failing capture in the same cycle keeps the error flag set.
      if (clear_err) begin
        rep_cnt    <= '0;
        hist_valid <= 1'b0;
        if (!((state == S_CAPTURE) && rep_trip)) health_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trng_seed_fetch.sv
// Directed + randomized bench for trng_seed_fetch with a byte-level reference model
// of word packing and the repetition health test.
module tb_trng_seed_fetch;
  localparam int WORD_W    = 32;
  localparam int REP_LIMIT = 4;
  localparam int BYTES     = WORD_W / 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [7:0]        fifo_rd_data = '0;
  logic              start = 1'b0;
  logic [3:0]        num_words = '0;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic              busy;
  logic              done;
  logic              health_err;
  logic              clear_err = 1'b0;
  logic [2:0]        state_dbg;

  trng_seed_fetch #(.WORD_W(WORD_W), .REP_LIMIT(REP_LIMIT)) dut (
    .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .start(start), .num_words(num_words),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .busy(busy), .done(done), .health_err(health_err), .clear_err(clear_err),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO model: data appears the cycle after the pop strobe
  logic [7:0] fifo_q[$];
  always_comb fifo_empty = (fifo_q.size() == 0);
  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
  end

  // downstream ready driver: 0 = always ready, 1 = random, 2 = held low
  int rdy_mode = 0;
  initial begin
    word_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      word_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // scoreboard
  logic [WORD_W-1:0] exp_q[$];
  int pops = 0;
  int dones = 0;
  logic stalled_prev = 1'b0;
  logic last_rd = 1'b0;
  logic [WORD_W-1:0] held_word = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      stalled_prev = 1'b0;
      last_rd = 1'b0;
    end else begin
      if (fifo_rd_en) begin
        pops++;
        chk("rd_single_pulse", last_rd, 1'b0);
      end
      last_rd = fifo_rd_en;
      if (done) dones++;
      if (word_valid) chk("rd_while_valid", fifo_rd_en, 1'b0);
      if (word_valid && stalled_prev) chk("word_hold", word_data, held_word);
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", word_data, '1 ^ word_data);
        else chk("word", word_data, exp_q.pop_front());
      end
      stalled_prev = word_valid && !word_ready;
      held_word = word_data;
    end
  end

  // reference model: byte stream -> words, repetition test, persistent history
  logic [7:0] bq[$];
  logic [7:0] m_prev = '0;
  int m_rep = 0;
  bit m_hv = 0;
  bit m_err = 0;
  int exp_pops_d, exp_done_d, pops_base, dones_base;

  task automatic model_fetch(input int n);
    logic [WORD_W-1:0] w;
    exp_pops_d = 0;
    exp_done_d = 0;
    if (m_err) return;
    w = '0;
    for (int i = 0; i < n * BYTES; i++) begin
      if (m_hv && bq[i] == m_prev) m_rep++;
      else m_rep = 1;
      m_prev = bq[i];
      m_hv = 1;
      exp_pops_d++;
      w = (w << 8) | WORD_W'(bq[i]);
      if (m_rep == REP_LIMIT) begin
        m_err = 1;
        return;
      end
      if ((i + 1) % BYTES == 0) begin
        exp_q.push_back(w);
        w = '0;
      end
    end
    exp_done_d = 1;
  endtask

  task automatic push_range(input int a, input int b);
    for (int i = a; i < b; i++) fifo_q.push_back(bq[i]);
  endtask

  // driver tasks
  task automatic start_fetch(input int n);
    model_fetch(n);
    pops_base = pops;
    dones_base = dones;
    @(posedge clk); #1;
    start = 1'b1;
    num_words = 4'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_fetch(input string tag);
    int cyc = 0;
    while (busy && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_timeout"}, (cyc >= 3000), 1'b0);
    @(negedge clk);
    chk({tag, "_err"}, health_err, m_err);
    chk({tag, "_pops"}, pops - pops_base, exp_pops_d);
    chk({tag, "_done"}, dones - dones_base, exp_done_d);
    chk({tag, "_words_left"}, exp_q.size(), 0);
    chk({tag, "_busy"}, busy, 1'b0);
    if (health_err) fifo_q.delete();
    exp_q.delete();
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    m_err = 0;
    m_rep = 0;
    m_hv = 0;
    @(negedge clk);
    chk("clear_err", health_err, 1'b0);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_rd_en"}, fifo_rd_en, 1'b0);
    chk({tag, "_data"}, word_data, '0);
    chk({tag, "_valid"}, word_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_herr"}, health_err, 1'b0);
    chk({tag, "_state"}, state_dbg, 3'd0);
  endtask

  initial begin
    int cyc;
    int n;
    // reset
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk_idle_zero("reset");

    // 1: single word, known bytes
    bq = '{8'h11, 8'h22, 8'h33, 8'h44};
    push_range(0, 4);
    start_fetch(1);
    chk("t1_exp_word", exp_q[0], 32'h11223344);
    finish_fetch("t1");

    // 2: two words, first held by ready low for 10 cycles
    bq.delete();
    for (int i = 0; i < 8; i++) bq.push_back(8'(8'h40 + i));
    push_range(0, 8);
    rdy_mode = 2;
    start_fetch(2);
    cyc = 0;
    while (!word_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("t2_valid_timeout", (cyc >= 200), 1'b0);
    repeat (10) @(negedge clk);
    chk("t2_still_valid", word_valid, 1'b1);
    chk("t2_pops_stalled", pops - pops_base, 4);
    chk("t2_no_done_yet", dones - dones_base, 0);
    rdy_mode = 0;
    finish_fetch("t2");

    // 3: num_words=0 -> 16 words, 64 distinct bytes
    bq.delete();
    n = $urandom_range(0, 255);
    for (int i = 0; i < 64; i++) bq.push_back(8'(n + i));
    push_range(0, 64);
    rdy_mode = 1;
    start_fetch(16);
    chk("t3_exp_words", exp_q.size(), 16);
    finish_fetch("t3");
    rdy_mode = 0;

    // 4: FIFO runs dry after two bytes for a while
    bq.delete();
    for (int i = 0; i < 4; i++) bq.push_back(8'($urandom_range(0, 127)) | 8'(i << 5));
    push_range(0, 2);
    start_fetch(1);
    repeat (20) @(negedge clk);
    chk("t4_pops_stalled", pops - pops_base, 2);
    chk("t4_no_valid", word_valid, 1'b0);
    chk("t4_busy", busy, 1'b1);
    push_range(2, 4);
    finish_fetch("t4");

    // 5: repetition failure, ignored start, clear and retry
    bq = '{8'hAA, 8'hAA, 8'hAA, 8'hAA};
    push_range(0, 4);
    start_fetch(1);
    finish_fetch("t5_fail");
    chk("t5_model_err", m_err, 1'b1);
    bq = '{8'h01, 8'h02, 8'h03, 8'h04};
    push_range(0, 4);
    start_fetch(1);
    repeat (4) @(negedge clk);
    chk("t5_ignored_busy", busy, 1'b0);
    finish_fetch("t5_ignored");
    do_clear();
    push_range(0, 4);
    start_fetch(1);
    finish_fetch("t5_retry");

    // 6: reset during CAPTURE of a 3-word fetch
    bq.delete();
    for (int i = 0; i < 12; i++) bq.push_back(8'(8'h80 + i));
    push_range(0, 12);
    start_fetch(3);
    cyc = 0;
    while (!(fifo_rd_en && (pops - pops_base) >= 2) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6_rd_timeout", (cyc >= 200), 1'b0);
    @(posedge clk); #1;
    chk("t6_in_capture", state_dbg, 3'd2);
    reset_n = 1'b0;
    #1;
    chk_idle_zero("t6_reset");
    fifo_q.delete();
    exp_q.delete();
    m_prev = '0; m_rep = 0; m_hv = 0; m_err = 0;
    @(posedge clk); #1 reset_n = 1'b1;
    bq = '{8'h5A, 8'hC3, 8'h0F, 8'hF0};
    push_range(0, 4);
    start_fetch(1);
    finish_fetch("t6_after");

    // random: mixed entropy bytes, random sizes and backpressure
    for (int it = 0; it < 12; it++) begin
      n = $urandom_range(1, 4);
      rdy_mode = $urandom_range(0, 1);
      bq.delete();
      for (int i = 0; i < n * BYTES; i++)
        bq.push_back((it % 3 == 2) ? (($urandom_range(0, 1) != 0) ? 8'hA5 : 8'h5A)
                                   : 8'($urandom_range(0, 255)));
      push_range(0, n * BYTES);
      start_fetch(n);
      finish_fetch("rnd");
      if (m_err) do_clear();
    end
    rdy_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=timeout expected=finish");
    $fatal(1, "global timeout");
  end
endmodule
